// File: rtl/score_digit_scheduler.sv
// Score-to-BCD converter (sequential double-dabble) feeding a round-robin
// arbiter that shares one digit-glyph ROM among the four display places.
module score_digit_scheduler #(
  parameter int DIGIT_SIZE = 900,
  parameter int MAX_SCORE  = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] score,
  input  logic        score_load,
  output logic        busy,
  output logic [3:0]  digit_ones,
  output logic [3:0]  digit_tens,
  output logic [3:0]  digit_hundreds,
  output logic [3:0]  digit_thousands,
  input  logic [3:0]  req,
  input  logic [9:0]  addr_ones,
  input  logic [9:0]  addr_tens,
  input  logic [9:0]  addr_hundreds,
  input  logic [9:0]  addr_thousands,
  output logic [3:0]  gnt,
  output logic [13:0] rom_addr,
  input  logic        rom_q,
  output logic        pix_valid,
  output logic [3:0]  pix_place,
  output logic        pix
);

  localparam logic [13:0] MAX_S = 14'(MAX_SCORE);
  localparam logic [13:0] DSIZE = 14'(DIGIT_SIZE);
  localparam logic [3:0]  LAST_STEP = 4'd13;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] digits_q, digits_d;

  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [13:0] rom_addr_q, rom_addr_d;
  logic        oob_q, oob_d;
  logic        pix_valid_q, pix_valid_d;
  logic [3:0]  pix_place_q, pix_place_d;
  logic        pix_kill_q, pix_kill_d;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in next bit.
  function automatic logic [15:0] dabble_step(input logic [15:0] b, input logic in_bit);
    logic [15:0] a;
    a = b;
    for (int unsigned i = 0; i < 4; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return (a << 1) | 16'(in_bit);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (score_load) state_d = CONV;
      CONV:    if (cnt_q == LAST_STEP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Conversion datapath
  always_comb begin
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    digits_d = digits_q;
    if (state_q == IDLE) begin
      if (score_load) begin
        bin_d = (score > MAX_S) ? MAX_S : score;
        bcd_d = '0;
        cnt_d = '0;
      end
    end else begin
      bcd_d = dabble_step(bcd_q, bin_q[13]);
      bin_d = bin_q << 1;
      cnt_d = cnt_q + 4'd1;
      // Published only on the final step so the display never shows a partial value.
      if (cnt_q == LAST_STEP) digits_d = bcd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      digits_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      digits_q <= digits_d;
    end
  end

  // Round-robin arbiter and ROM address generation
  always_comb begin
    logic       found;
    logic [1:0] gidx;
    logic [1:0] idx;
    logic [3:0] sel_digit;
    logic [9:0] sel_addr;
    logic       oob;
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    case (gidx)
      2'd0:    begin sel_digit = digits_q[3:0];   sel_addr = addr_ones;      end
      2'd1:    begin sel_digit = digits_q[7:4];   sel_addr = addr_tens;      end
      2'd2:    begin sel_digit = digits_q[11:8];  sel_addr = addr_hundreds;  end
      default: begin sel_digit = digits_q[15:12]; sel_addr = addr_thousands; end
    endcase
    oob = ({4'b0, sel_addr} >= DSIZE);

    gnt_d      = found ? (4'b0001 << gidx) : '0;
    ptr_d      = found ? gidx + 2'd1 : ptr_q;
    oob_d      = found & oob;
    rom_addr_d = rom_addr_q;
    if (found)
      rom_addr_d = {10'b0, sel_digit} * DSIZE + (oob ? 14'd0 : {4'b0, sel_addr});

    pix_valid_d = |gnt_q;
    pix_place_d = gnt_q;
    pix_kill_d  = oob_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      rom_addr_q  <= '0;
      oob_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_place_q <= '0;
      pix_kill_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rom_addr_q  <= rom_addr_d;
      oob_q       <= oob_d;
      pix_valid_q <= pix_valid_d;
      pix_place_q <= pix_place_d;
      pix_kill_q  <= pix_kill_d;
    end
  end

  // Output logic
  always_comb begin
    busy            = (state_q == CONV);
    digit_ones      = digits_q[3:0];
    digit_tens      = digits_q[7:4];
    digit_hundreds  = digits_q[11:8];
    digit_thousands = digits_q[15:12];
    gnt             = gnt_q;
    rom_addr        = rom_addr_q;
    pix_valid       = pix_valid_q;
    pix_place       = pix_place_q;
    pix             = pix_valid_q & ~pix_kill_q & rom_q;
  end

endmodule

// File: tb/tb_score_digit_scheduler.sv
// Directed bench for score_digit_scheduler: conversion, saturation, arbitration,
// out-of-range pixel addresses and reset behaviour.
module tb_score_digit_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] score;
  logic        score_load;
  logic        busy;
  logic [3:0]  digit_ones, digit_tens, digit_hundreds, digit_thousands;
  logic [3:0]  req;
  logic [9:0]  addr_ones, addr_tens, addr_hundreds, addr_thousands;
  logic [3:0]  gnt;
  logic [13:0] rom_addr;
  logic        rom_q;
  logic        pix_valid;
  logic [3:0]  pix_place;
  logic        pix;
  logic        rom_force;

  int total = 0;
  int bad   = 0;

  score_digit_scheduler #(.DIGIT_SIZE(900), .MAX_SCORE(9999)) dut (
    .clk(clk), .reset(reset), .score(score), .score_load(score_load), .busy(busy),
    .digit_ones(digit_ones), .digit_tens(digit_tens),
    .digit_hundreds(digit_hundreds), .digit_thousands(digit_thousands),
    .req(req), .addr_ones(addr_ones), .addr_tens(addr_tens),
    .addr_hundreds(addr_hundreds), .addr_thousands(addr_thousands),
    .gnt(gnt), .rom_addr(rom_addr), .rom_q(rom_q),
    .pix_valid(pix_valid), .pix_place(pix_place), .pix(pix)
  );

  always #5 clk = ~clk;

  // ROM stand-in: registered, data pattern = addr[0] ^ addr[2]
  function automatic logic romf(input logic [13:0] a);
    return a[0] ^ a[2];
  endfunction

  always @(posedge clk) rom_q <= rom_force ? 1'b1 : romf(rom_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] digits;
    return {digit_thousands, digit_hundreds, digit_tens, digit_ones};
  endfunction

  task automatic do_reset;
    reset = 1'b1; score_load = 1'b0; req = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    repeat (5) tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (digits() !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%0h exp=0", digits()); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (rom_addr !== 14'd0) begin bad++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    total++; if ({pix_valid, pix_place, pix} !== 6'b0) begin bad++;
      $display("FAIL reset_pix got=%b/%b/%b exp=0/0000/0", pix_valid, pix_place, pix); end
  endtask

  // Pulse a load, check busy for 14 cycles with old digits held, then final digits.
  task automatic load_check(input string name, input logic [13:0] s, input logic [15:0] exp_bcd,
                            input logic [15:0] old_bcd, input bit inject);
    score = s; score_load = 1'b1;
    tick;
    for (int i = 1; i <= 14; i++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy cyc=%0d got=%0b exp=1", name, i, busy); end
      total++; if (digits() !== old_bcd) begin bad++;
        $display("FAIL %s_hold cyc=%0d got=%0h exp=%0h", name, i, digits(), old_bcd); end
      score_load = inject && (i == 5);
      if (inject) score = 14'd5;
      tick;
    end
    score_load = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end got=%0b exp=0", name, busy); end
    total++; if (digits() !== exp_bcd) begin bad++;
      $display("FAIL %s_digits got=%0h exp=%0h", name, digits(), exp_bcd); end
    if (inject) begin
      tick;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_no_queue got=%0b exp=0", name, busy); end
    end
  endtask

  task automatic test_convert;
    load_check("conv1234", 14'd1234, 16'h1234, 16'h0000, 1'b1);
  endtask

  task automatic test_saturate;
    load_check("sat12000", 14'd12000, 16'h9999, 16'h1234, 1'b0);
    load_check("zero", 14'd0, 16'h0000, 16'h9999, 1'b0);
  endtask

  task automatic test_rr_all;
    logic [13:0] exp_a [4];
    logic [3:0]  prev_g;
    logic [13:0] prev_a;
    exp_a[0] = 14'd3605; exp_a[1] = 14'd2705; exp_a[2] = 14'd1805; exp_a[3] = 14'd905;
    do_reset;
    load_check("load1234", 14'd1234, 16'h1234, 16'h0000, 1'b0);
    addr_ones = 10'd5; addr_tens = 10'd5; addr_hundreds = 10'd5; addr_thousands = 10'd5;
    req = 4'b1111;
    prev_g = '0; prev_a = '0;
    for (int k = 0; k < 8; k++) begin
      tick;
      total++; if (gnt !== (4'b0001 << (k % 4))) begin bad++;
        $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, 4'b0001 << (k % 4)); end
      total++; if (rom_addr !== exp_a[k % 4]) begin bad++;
        $display("FAIL rr_addr k=%0d got=%0d exp=%0d", k, rom_addr, exp_a[k % 4]); end
      if (k > 0) begin
        total++; if ({pix_valid, pix_place, pix} !== {1'b1, prev_g, romf(prev_a)}) begin bad++;
          $display("FAIL rr_pix k=%0d got=%b/%b/%b exp=1/%b/%b", k, pix_valid, pix_place, pix, prev_g, romf(prev_a)); end
      end
      prev_g = 4'b0001 << (k % 4);
      prev_a = exp_a[k % 4];
    end
    req = '0;
    tick;
    total++; if (gnt !== 4'b0000 || rom_addr !== 14'd905) begin bad++;
      $display("FAIL rr_idle got=%b/%0d exp=0000/905", gnt, rom_addr); end
    total++; if (pix_valid !== 1'b1 || pix_place !== 4'b1000) begin bad++;
      $display("FAIL rr_last_pix got=%b/%b exp=1/1000", pix_valid, pix_place); end
    tick;
    total++; if (pix_valid !== 1'b0 || pix !== 1'b0) begin bad++;
      $display("FAIL rr_drain got=%b/%b exp=0/0", pix_valid, pix); end
  endtask

  task automatic test_rr_partial;
    logic [3:0]  exp_g [3];
    logic [13:0] exp_a [3];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
    exp_a[0] = 14'd2705; exp_a[1] = 14'd905; exp_a[2] = 14'd2705;
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick;
      total++; if (gnt !== exp_g[k] || rom_addr !== exp_a[k]) begin bad++;
        $display("FAIL rrp k=%0d got=%b/%0d exp=%b/%0d", k, gnt, rom_addr, exp_g[k], exp_a[k]); end
    end
    req = '0;
    tick; tick;
  endtask

  task automatic test_oob;
    rom_force = 1'b1;
    req = 4'b0010; addr_tens = 10'd950;
    tick;
    total++; if (gnt !== 4'b0010 || rom_addr !== 14'd2700) begin bad++;
      $display("FAIL oob_addr got=%b/%0d exp=0010/2700", gnt, rom_addr); end
    addr_tens = 10'd899;
    tick;
    total++; if (rom_addr !== 14'd3599) begin bad++; $display("FAIL edge_addr got=%0d exp=3599", rom_addr); end
    total++; if (pix_valid !== 1'b1 || pix !== 1'b0) begin bad++;
      $display("FAIL oob_pix got=%b/%b exp=1/0", pix_valid, pix); end
    req = '0;
    tick;
    total++; if (pix_valid !== 1'b1 || pix !== 1'b1) begin bad++;
      $display("FAIL edge_pix got=%b/%b exp=1/1", pix_valid, pix); end
    rom_force = 1'b0; addr_tens = 10'd5;
    tick;
  endtask

  task automatic test_load_with_req;
    score = 14'd5678; score_load = 1'b1; req = 4'b0001;
    tick;
    score_load = 1'b0; req = '0;
    total++; if (busy !== 1'b1 || gnt !== 4'b0001 || rom_addr !== 14'd3605) begin bad++;
      $display("FAIL load_req got=%b/%b/%0d exp=1/0001/3605", busy, gnt, rom_addr); end
    repeat (13) tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL load_req_busy got=%0b exp=1", busy); end
    tick;
    total++; if (busy !== 1'b0 || digits() !== 16'h5678) begin bad++;
      $display("FAIL load_req_digits got=%0b/%0h exp=0/5678", busy, digits()); end
  endtask

  task automatic test_reset_mid;
    score = 14'd1111; score_load = 1'b1;
    tick;
    score_load = 1'b0;
    repeat (6) tick;
    reset = 1'b1; score_load = 1'b1; req = 4'b1111;
    tick;
    total++; if (busy !== 1'b0 || digits() !== 16'h0000 || gnt !== 4'b0000) begin bad++;
      $display("FAIL reset_mid got=%b/%0h/%b exp=0/0/0000", busy, digits(), gnt); end
    reset = 1'b0; score_load = 1'b0; req = '0;
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_prio got=%0b exp=0", busy); end
    load_check("load42", 14'd42, 16'h0042, 16'h0000, 1'b0);
    req = 4'b1111;
    tick;
    total++; if (gnt !== 4'b0001 || rom_addr !== 14'd1805) begin bad++;
      $display("FAIL ptr_reset got=%b/%0d exp=0001/1805", gnt, rom_addr); end
    req = '0;
    tick;
  endtask

  initial begin
    reset = 1'b1; score = '0; score_load = 1'b0; req = '0; rom_force = 1'b0;
    addr_ones = '0; addr_tens = '0; addr_hundreds = '0; addr_thousands = '0;
    test_reset;
    test_convert;
    test_saturate;
    test_rr_all;
    test_rr_partial;
    test_oob;
    test_load_with_req;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
